// File: rtl/mdu_scheduler.sv
// Multiply/divide unit scheduler: serialises MULT/MULTU/DIV/DIVU into a busy window and owns HI/LO; MTHI/MTLO write directly.
// Latency: MULT_CYCLES or DIV_CYCLES from accepted start to done; HI/LO are updated on the edge that ends the done cycle.
// Backpressure: start is ignored while busy; stall freezes the D stage while an MDU user is waiting. Optional feature: MDU_DIVZERO_EN.
module mdu_scheduler #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall
`ifdef MDU_DIVZERO_EN
  ,
  output logic        divzero
`endif
);

  localparam logic [3:0] MULT_CNT = MULT_CYCLES[3:0];
  localparam logic [3:0] DIV_CNT  = DIV_CYCLES[3:0];

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept, commit, mt_hi, mt_lo;
  logic [31:0] opa, opb;
  logic        sgn;
  logic [31:0] res_hi, res_lo;

  // Live operation state: state and down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: only IDLE accepts new work; busy states count down to commit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    commit    = 1'b0;
    mt_hi     = 1'b0;
    mt_lo     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          case (op)
            3'd0, 3'd1: begin
              state_nxt = S_MUL;
              cnt_nxt   = MULT_CNT;
              accept    = 1'b1;
            end
            3'd2, 3'd3: begin
              state_nxt = S_DIV;
              cnt_nxt   = DIV_CNT;
              accept    = 1'b1;
            end
            3'd4:    mt_hi = 1'b1;
            3'd5:    mt_lo = 1'b1;
            default: ;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = S_IDLE;
          commit    = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy  = (state != S_IDLE);
  assign done  = busy && (cnt == 4'd1);
  assign stall = d_req & (busy | (start & (op <= 3'd3)));

  // Operand capture; odd opcodes (MULTU/DIVU) are the unsigned variants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa <= 32'd0;
      opb <= 32'd0;
      sgn <= 1'b0;
    end else if (accept) begin
      opa <= a;
      opb <= b;
      sgn <= ~op[0];
    end
  end

  logic [63:0] a_ext, b_ext, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_den, q_mag, r_mag;

  // Result datapath: 64-bit multiply of extended operands; divide on magnitudes then re-apply signs,
  // which also yields 0x80000000 / -1 = 0x80000000 rem 0 without overflow special-casing.
  always_comb begin
    a_ext  = sgn ? {{32{opa[31]}}, opa} : {32'd0, opa};
    b_ext  = sgn ? {{32{opb[31]}}, opb} : {32'd0, opb};
    prod   = a_ext * b_ext;
    a_neg  = sgn & opa[31];
    b_neg  = sgn & opb[31];
    a_mag  = a_neg ? (~opa + 32'd1) : opa;
    b_mag  = b_neg ? (~opb + 32'd1) : opb;
    b_den  = (opb == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_den;
    r_mag  = a_mag % b_den;
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (state == S_DIV) begin
      if (opb == 32'd0) begin
`ifdef MDU_DIVZERO_EN
        res_hi = hi;
        res_lo = lo;
`else
        res_hi = opa;
        res_lo = 32'hFFFF_FFFF;
`endif
      end else begin
        res_lo = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        res_hi = a_neg ? (~r_mag + 32'd1) : r_mag;
      end
    end
  end

`ifdef MDU_DIVZERO_EN
  assign divzero = done && (state == S_DIV) && (opb == 32'd0);
`endif

  // Architectural HI/LO: written only at commit or by an accepted MTHI/MTLO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (commit) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (mt_hi) begin
      hi <= a;
    end else if (mt_lo) begin
      lo <= a;
    end
  end

endmodule

// File: tb/tb_mdu_scheduler.sv
module tb_mdu_scheduler;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        d_req = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done, stall;
`ifdef MDU_DIVZERO_EN
  logic        dz_obs;
`endif

  mdu_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .d_req(d_req),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
`ifdef MDU_DIVZERO_EN
    , .divzero(dz_obs)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endfunction

  // Reference model: architectural HI/LO plus the window in which the unit is busy.
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  int issue_at = 0, free_at = 0;

  typedef struct {
    int          done_cyc;
    logic [31:0] old_hi, old_lo, new_hi, new_lo;
    bit          dz;
  } mdu_exp_t;
  typedef struct {
    int          due;
    logic [31:0] hi, lo;
  } mt_exp_t;

  mdu_exp_t mq[$];
  mt_exp_t  tq[$];
  bit       pend = 1'b0;
  mdu_exp_t pend_e;

  function automatic void ref_op(input logic [2:0] o, input logic [31:0] av, bv, ohi, olo,
                                 output logic [31:0] nh, nl, output bit dz);
    longint          sp, sa, sb, q, r;
    longint unsigned up;
    dz = 1'b0;
    nh = ohi;
    nl = olo;
    case (o)
      3'd0: begin
        sp = longint'($signed(av)) * longint'($signed(bv));
        nh = sp[63:32]; nl = sp[31:0];
      end
      3'd1: begin
        up = longint'(av) * longint'(bv);
        nh = up[63:32]; nl = up[31:0];
      end
      default: begin
        if (bv == 32'd0) begin
`ifdef MDU_DIVZERO_EN
          dz = 1'b1;
`else
          nh = av; nl = 32'hFFFF_FFFF;
`endif
        end else if (o == 3'd2) begin
          sa = longint'($signed(av)); sb = longint'($signed(bv));
          q = sa / sb; r = sa % sb;
          nl = q[31:0]; nh = r[31:0];
        end else begin
          nl = av / bv; nh = av % bv;
        end
      end
    endcase
  endfunction

  // Present inputs for the current cycle and advance the model by the acceptance rules.
  task automatic drive(input bit st, input logic [2:0] o, input logic [31:0] av, bv, input bit dr);
    logic [31:0] nh, nl;
    bit dz;
    int n;
    start = st; op = o; a = av; b = bv; d_req = dr;
    if (st && rst_n && cyc >= free_at) begin
      if (o <= 3'd3) begin
        n = (o <= 3'd1) ? MC : DC;
        ref_op(o, av, bv, m_hi, m_lo, nh, nl, dz);
        issue_at = cyc;
        free_at  = cyc + n + 1;
        mq.push_back('{cyc + n, m_hi, m_lo, nh, nl, dz});
        m_hi = nh; m_lo = nl;
      end else if (o == 3'd4) begin
        m_hi = av;
        tq.push_back('{cyc + 1, m_hi, m_lo});
      end else if (o == 3'd5) begin
        m_lo = av;
        tq.push_back('{cyc + 1, m_hi, m_lo});
      end
    end
  endtask

  task automatic cycle(input bit st, input logic [2:0] o, input logic [31:0] av, bv, input bit dr);
    @(posedge clk); #1;
    drive(st, o, av, bv, dr);
  endtask

  task automatic idle(input int n, input bit dr);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 32'd0, 32'd0, dr);
  endtask

  // Mid-cycle asynchronous reset; optionally the release cycle carries a start (first edge must accept it).
  task automatic do_reset(input bit rel_start, input logic [2:0] o, input logic [31:0] av, bv, input bit dr);
    @(posedge clk); #1;
    rst_n = 1'b0;
    start = 1'b0; d_req = 1'b0;
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    mq.delete(); tq.delete(); pend = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0; issue_at = 0; free_at = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(rel_start, o, av, bv, dr);
  endtask

  // Monitor: busy/stall every cycle; done pops the scoreboard; HI/LO checked the cycle after commit or MT*.
  always @(negedge clk) begin
    bit exp_busy, exp_done;
    mdu_exp_t e;
    mt_exp_t t;
    if (rst_n) begin
      exp_busy = (cyc > issue_at) && (cyc < free_at);
      chk("busy", busy, exp_busy);
      chk("stall", stall, d_req & (exp_busy | (start & (op <= 3'd3))));
      if (pend) begin
        chk("commit_hi", hi, pend_e.new_hi);
        chk("commit_lo", lo, pend_e.new_lo);
        pend = 1'b0;
      end
      exp_done = (mq.size() > 0) && (mq[0].done_cyc == cyc);
      chk("done", done, exp_done);
      if (exp_done) begin
        e = mq.pop_front();
        chk("hold_hi", hi, e.old_hi);
        chk("hold_lo", lo, e.old_lo);
`ifdef MDU_DIVZERO_EN
        chk("divzero", dz_obs, e.dz);
`endif
        pend_e = e;
        pend = 1'b1;
      end
      if (tq.size() > 0 && tq[0].due == cyc) begin
        t = tq.pop_front();
        chk("mt_hi", hi, t.hi);
        chk("mt_lo", lo, t.lo);
      end
    end
  end

  logic [31:0] corner[6];

  function automatic logic [31:0] pick();
    return ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : $urandom();
  endfunction

  initial begin
    int guard;
    corner[0] = 32'd0;        corner[1] = 32'h8000_0000; corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'd1;        corner[4] = 32'd7;         corner[5] = 32'h7FFF_FFFF;

    #2 rst_n = 1'b0;
    #1;
    chk("init_hi", hi, 0);
    chk("init_lo", lo, 0);
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);

    // MULT -2 * 3 issued in the reset-release cycle, D stage requesting throughout.
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b1, 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1);
    idle(5, 1'b1);
    idle(3, 1'b0);

    cycle(1'b1, 3'd3, 32'd100, 32'd7, 1'b0);
    idle(12, 1'b0);
    cycle(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle(12, 1'b0);

    // Same MULT without d_req: stall must stay low.
    cycle(1'b1, 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    idle(7, 1'b0);

    // MTLO while idle, then MTHI while busy (ignored).
    cycle(1'b1, 3'd5, 32'h1234_5678, 32'd0, 1'b0);
    idle(2, 1'b0);
    cycle(1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    cycle(1'b1, 3'd4, 32'hDEAD_BEEF, 32'd0, 1'b1);
    idle(6, 1'b0);

    // Signed overflow case and divide by zero with HI/LO preset.
    cycle(1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(12, 1'b0);
    cycle(1'b1, 3'd4, 32'h11, 32'd0, 1'b0);
    cycle(1'b1, 3'd5, 32'h11, 32'd0, 1'b0);
    cycle(1'b1, 3'd2, 32'd5, 32'd0, 1'b0);
    idle(12, 1'b0);

    // Reset four cycles into a DIV: aborted, no done, HI/LO stay zero.
    cycle(1'b1, 3'd2, 32'd50, 32'd3, 1'b0);
    idle(3, 1'b0);
    do_reset(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    idle(15, 1'b0);
    chk("post_abort_hi", hi, 0);
    chk("post_abort_lo", lo, 0);

    // Randomised traffic, including starts while busy and reserved opcodes.
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)));

    guard = 0;
    while ((mq.size() > 0 || tq.size() > 0 || pend) && guard < 40) begin
      idle(1, 1'b0);
      guard++;
    end
    @(posedge clk); #1;
    if (mq.size() > 0 || tq.size() > 0 || pend) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d operations still outstanding, required 0", mq.size() + tq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
